// File: rtl/bram_dp.sv
// True dual-port block RAM with byte-lane write strobes, selectable read/write
// ordering, 1- or 2-cycle read latency and an optional zero-fill engine after reset.
module bram_dp #(
  parameter int RAM_WIDTH      = 32,
  parameter int RAM_ADDR_BITS  = 9,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                clock,
  input  logic                                reset,
  output logic                                clear_busy,

  input  logic                                a_enable,
  input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     a_write_enable,
  input  logic [RAM_ADDR_BITS-1:0]            a_address,
  input  logic [RAM_WIDTH-1:0]                a_input_data,
  output logic [RAM_WIDTH-1:0]                a_output_data,
  output logic                                a_valid,

  input  logic                                b_enable,
  input  logic [RAM_WIDTH/BYTE_WIDTH-1:0]     b_write_enable,
  input  logic [RAM_ADDR_BITS-1:0]            b_address,
  input  logic [RAM_WIDTH-1:0]                b_input_data,
  output logic [RAM_WIDTH-1:0]                b_output_data,
  output logic                                b_valid
);

  localparam int NBYTES = RAM_WIDTH / BYTE_WIDTH;
  localparam int DEPTH  = 2 ** RAM_ADDR_BITS;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [RAM_ADDR_BITS-1:0] clear_count;
  logic [RAM_ADDR_BITS-1:0] clear_count_next;

  (* RAM_STYLE = "BLOCK" *) logic [RAM_WIDTH-1:0] mem [DEPTH];

  logic                 a_accept;
  logic                 b_accept;
  logic [RAM_WIDTH-1:0] a_word;
  logic [RAM_WIDTH-1:0] b_word;
  logic [RAM_WIDTH-1:0] a_merged;
  logic [RAM_WIDTH-1:0] b_merged;
  logic [RAM_WIDTH-1:0] a_return;
  logic [RAM_WIDTH-1:0] b_return;

  logic [RAM_WIDTH-1:0] a_s1_data;
  logic                 a_s1_valid;
  logic [RAM_WIDTH-1:0] b_s1_data;
  logic                 b_s1_valid;

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET != 0) begin
        state <= CLEAR;
      end else begin
        state <= IDLE;
      end
      clear_count <= '0;
    end else begin
      state       <= state_next;
      clear_count <= clear_count_next;
    end
  end

  always_comb begin
    state_next       = state;
    clear_count_next = clear_count;
    case (state)
      IDLE: begin
        clear_count_next = '0;
      end
      CLEAR: begin
        if (clear_count == '1) begin
          state_next       = IDLE;
          clear_count_next = '0;
        end else begin
          clear_count_next = clear_count + 1'b1;
        end
      end
      default: begin
        state_next       = IDLE;
        clear_count_next = '0;
      end
    endcase
  end

  assign clear_busy = (state == CLEAR);

  assign a_accept = a_enable && !reset && !clear_busy;
  assign b_accept = b_enable && !reset && !clear_busy;

  // ---------------------------------------------------------------------------
  // Read data selection
  // ---------------------------------------------------------------------------
  assign a_word = mem[a_address];
  assign b_word = mem[b_address];

  // Write-first returns only this port's own merge; the other port's
  // same-cycle write is never visible to this reader.
  always_comb begin
    a_merged = a_word;
    b_merged = b_word;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (a_write_enable[i]) begin
        a_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = a_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (b_write_enable[i]) begin
        b_merged[i*BYTE_WIDTH +: BYTE_WIDTH] = b_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign a_return = (WRITE_MODE == 1) ? a_merged : a_word;
  assign b_return = (WRITE_MODE == 1) ? b_merged : b_word;

  // ---------------------------------------------------------------------------
  // Memory array writes
  // ---------------------------------------------------------------------------
  // Port A lanes are written after port B's so A wins on overlapping lanes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (clear_busy) begin
        mem[clear_count] <= '0;
      end else begin
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (b_enable && b_write_enable[i]) begin
            mem[b_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= b_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
        for (int unsigned i = 0; i < NBYTES; i++) begin
          if (a_enable && a_write_enable[i]) begin
            mem[a_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= a_input_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First read stage: data only loads on an accepted access so it holds otherwise
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      a_s1_data  <= '0;
      a_s1_valid <= 1'b0;
      b_s1_data  <= '0;
      b_s1_valid <= 1'b0;
    end else begin
      a_s1_valid <= a_accept;
      b_s1_valid <= b_accept;
      if (a_accept) begin
        a_s1_data <= a_return;
      end
      if (b_accept) begin
        b_s1_data <= b_return;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional output register stage
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] a_s2_data;
      logic                 a_s2_valid;
      logic [RAM_WIDTH-1:0] b_s2_data;
      logic                 b_s2_valid;

      always_ff @(posedge clock) begin
        if (reset) begin
          a_s2_data  <= '0;
          a_s2_valid <= 1'b0;
          b_s2_data  <= '0;
          b_s2_valid <= 1'b0;
        end else begin
          a_s2_valid <= a_s1_valid;
          b_s2_valid <= b_s1_valid;
          if (a_s1_valid) begin
            a_s2_data <= a_s1_data;
          end
          if (b_s1_valid) begin
            b_s2_data <= b_s1_data;
          end
        end
      end

      assign a_output_data = a_s2_data;
      assign a_valid       = a_s2_valid;
      assign b_output_data = b_s2_data;
      assign b_valid       = b_s2_valid;
    end else begin : g_lat1
      assign a_output_data = a_s1_data;
      assign a_valid       = a_s1_valid;
      assign b_output_data = b_s1_data;
      assign b_valid       = b_s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// Bench for bram_dp: two instances (latency 1 read-first, latency 2 write-first)
// share stimulus and are checked every cycle against a word-level memory model.
module tb_bram_dp;

  logic        clock = 1'b0;
  logic        reset;
  logic        a_en, b_en;
  logic [3:0]  a_we, b_we;
  logic [3:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din;

  logic        busy0, busy1;
  logic [31:0] a_dout0, b_dout0, a_dout1, b_dout1;
  logic        a_vld0, b_vld0, a_vld1, b_vld1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  bram_dp #(
    .RAM_WIDTH(32), .RAM_ADDR_BITS(4), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1)
  ) dut0 (
    .clock(clock), .reset(reset), .clear_busy(busy0),
    .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr),
    .a_input_data(a_din), .a_output_data(a_dout0), .a_valid(a_vld0),
    .b_enable(b_en), .b_write_enable(b_we), .b_address(b_addr),
    .b_input_data(b_din), .b_output_data(b_dout0), .b_valid(b_vld0)
  );

  bram_dp #(
    .RAM_WIDTH(32), .RAM_ADDR_BITS(4), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .WRITE_MODE(1), .CLEAR_ON_RESET(1)
  ) dut1 (
    .clock(clock), .reset(reset), .clear_busy(busy1),
    .a_enable(a_en), .a_write_enable(a_we), .a_address(a_addr),
    .a_input_data(a_din), .a_output_data(a_dout1), .a_valid(a_vld1),
    .b_enable(b_en), .b_write_enable(b_we), .b_address(b_addr),
    .b_input_data(b_din), .b_output_data(b_dout1), .b_valid(b_vld1)
  );

  // ---------------- reference model ----------------
  logic [31:0] mm [16];
  int          clear_left = 0;
  bit          v0 [2];
  logic [31:0] h0 [2];
  bit          v1 [2][2];
  logic [31:0] d1 [2][2];
  logic [31:0] h1 [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = din[8*i +: 8];
    return r;
  endfunction

  task automatic push(input int p, input bit v, input logic [31:0] r0, input logic [31:0] r1);
    v0[p] = v;
    if (v) h0[p] = r0;
    v1[p][1] = v1[p][0];
    d1[p][1] = d1[p][0];
    v1[p][0] = v;
    d1[p][0] = r1;
    if (v1[p][1]) h1[p] = d1[p][1];
  endtask

  task automatic model_tick();
    logic [31:0] oa, ob;
    bit acc_a, acc_b;
    if (reset) begin
      clear_left = 16;
      for (int p = 0; p < 2; p++) begin
        v0[p] = 0; h0[p] = '0; h1[p] = '0;
        for (int k = 0; k < 2; k++) begin v1[p][k] = 0; d1[p][k] = '0; end
      end
      return;
    end
    acc_a = a_en && (clear_left == 0);
    acc_b = b_en && (clear_left == 0);
    if (clear_left > 0) begin
      mm[16 - clear_left] = '0;
      clear_left--;
    end
    oa = mm[a_addr];
    ob = mm[b_addr];
    if (acc_b) mm[b_addr] = merge(mm[b_addr], b_din, b_we);
    if (acc_a) mm[a_addr] = merge(mm[a_addr], a_din, a_we);
    push(0, acc_a, oa, merge(oa, a_din, a_we));
    push(1, acc_b, ob, merge(ob, b_din, b_we));
  endtask

  task automatic compare_all();
    logic [31:0] busy_exp;
    busy_exp = (clear_left > 0) ? 32'd1 : 32'd0;
    check_eq("busy0",   {31'b0, busy0},  busy_exp);
    check_eq("busy1",   {31'b0, busy1},  busy_exp);
    check_eq("a_vld0",  {31'b0, a_vld0}, {31'b0, v0[0]});
    check_eq("b_vld0",  {31'b0, b_vld0}, {31'b0, v0[1]});
    check_eq("a_dout0", a_dout0, h0[0]);
    check_eq("b_dout0", b_dout0, h0[1]);
    check_eq("a_vld1",  {31'b0, a_vld1}, {31'b0, v1[0][1]});
    check_eq("b_vld1",  {31'b0, b_vld1}, {31'b0, v1[1][1]});
    check_eq("a_dout1", a_dout1, h1[0]);
    check_eq("b_dout1", b_dout1, h1[1]);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock);
    #1;
    model_tick();
    compare_all();
  endtask

  task automatic idle();
    reset = 1'b0;
    a_en = 1'b0; a_we = '0; a_addr = '0; a_din = '0;
    b_en = 1'b0; b_we = '0; b_addr = '0; b_din = '0;
  endtask

  task automatic drive_a(input bit en, input logic [3:0] we, input logic [3:0] addr,
                         input logic [31:0] d);
    a_en = en; a_we = we; a_addr = addr; a_din = d;
  endtask

  task automatic drive_b(input bit en, input logic [3:0] we, input logic [3:0] addr,
                         input logic [31:0] d);
    b_en = en; b_we = we; b_addr = addr; b_din = d;
  endtask

  // Counts busy cycles while port A attempts a write that must be ignored.
  task automatic measure_clear(input string tag);
    int count;
    count = 0;
    drive_a(1'b1, 4'hF, 4'd9, 32'h12345678);
    for (int k = 0; k < 40; k++) begin
      if (!busy0) break;
      count++;
      step();
    end
    idle();
    check_eq(tag, count, 32'd16);
    drive_a(1'b1, 4'h0, 4'd9, 32'h0);
    step();
    check_eq({tag, "_a9_0"}, a_dout0, 32'h0);
    idle();
    step();
    check_eq({tag, "_a9_1"}, a_dout1, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    measure_clear("clr_len");

    // All words read back zero after the clear.
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'h0, 4'(i), 32'h0);
      step();
    end
    idle();
    step();
    step();

    // Byte-lane merge.
    drive_a(1'b1, 4'hF, 4'd3, 32'hDEADBEEF); step();
    drive_a(1'b1, 4'b0101, 4'd3, 32'h11223344); step();
    drive_a(1'b1, 4'h0, 4'd3, 32'h0); step();
    check_eq("lane_merge0", a_dout0, 32'hDE22BE44);
    idle(); step();
    check_eq("lane_merge1", a_dout1, 32'hDE22BE44);

    // Read-first vs write-first return data.
    drive_a(1'b1, 4'hF, 4'd5, 32'hAAAAAAAA); step();
    drive_a(1'b1, 4'hF, 4'd5, 32'h55555555); step();
    check_eq("rd_first0", a_dout0, 32'hAAAAAAAA);
    idle(); step();
    check_eq("wr_first1", a_dout1, 32'h55555555);

    // Same-address collision: A owns lane 0.
    drive_a(1'b1, 4'b0001, 4'd7, 32'h000000FF);
    drive_b(1'b1, 4'hF, 4'd7, 32'hFFFFFF00);
    step();
    idle();
    drive_a(1'b1, 4'h0, 4'd7, 32'h0); step();
    check_eq("collide0", a_dout0, 32'hFFFFFFFF);
    idle(); step();
    check_eq("collide1", a_dout1, 32'hFFFFFFFF);

    // Reader sees old data while the other port writes the same word.
    drive_a(1'b1, 4'h0, 4'd7, 32'h0);
    drive_b(1'b1, 4'hF, 4'd7, 32'h01020304);
    step();
    check_eq("xport_old0", a_dout0, 32'hFFFFFFFF);
    idle(); step();
    check_eq("xport_old1", a_dout1, 32'hFFFFFFFF);

    // Back-to-back B reads of distinct words.
    for (int i = 0; i < 16; i++) begin
      drive_a(1'b1, 4'hF, 4'(i), {4{8'(i)}} ^ 32'hA5000000);
      step();
    end
    idle();
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      drive_b(1'b1, 4'h0, 4'(i), 32'h0);
      step();
      pulses += int'(b_vld1);
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      pulses += int'(b_vld1);
    end
    check_eq("b2b_pulses", pulses, 32'd16);

    // Reset part-way through the clear restarts it.
    reset = 1'b1; step();
    idle();
    for (int i = 0; i < 8; i++) step();
    reset = 1'b1; step();
    reset = 1'b0;
    measure_clear("midclr_len");

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      a_en = 1'($urandom); b_en = 1'($urandom);
      a_we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      b_we = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      a_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      b_addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 1)) : 4'($urandom);
      a_din = $urandom; b_din = $urandom;
      step();
    end
    idle();
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
